keypad_entry_ctrl: RTL and testbench

//   Sequences raw 10-key keypad input into a 4-digit MM:SS BCD time entry for the timer path.
//   - Debounces each press and encodes it: one-hot bit i -> BCD value i.
//   - Shifts accepted digits in from the right, as on a microwave keypad.
//   - Holds the entry until it is cleared; gates entry with enablen.

---
 rtl/keypad_entry_ctrl.sv | 149 ++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces a raw 10-key keypad and shifts accepted
// digits into a 4-digit MM:SS BCD entry from the right, microwave-style.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   keyboard   - raw keypad lines, bit i high = key i pressed
//   enablen    - active-low entry enable (high freezes the entry)
//   clear      - synchronous clear of the entry
//   sec_ones   - BCD digit 0 (most recent key)
//   sec_tens   - BCD digit 1
//   min_ones   - BCD digit 2
//   min_tens   - BCD digit 3 (oldest key)
//   digit_cnt  - number of digits entered, 0..4
//   key_valid  - one-cycle pulse when an accepted digit appears
//   entry_full - high while digit_cnt == 4
module keypad_entry_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keyboard,
  input  logic       enablen,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [2:0] digit_cnt,
  output logic       key_valid,
  output logic       entry_full
);

  localparam logic [7:0] DebMax = 8'(DEB_CYCLES);

  typedef enum logic [1:0] {StIdle, StDebounce, StWaitRel} state_e;

  state_e      state_q, state_d;
  logic [7:0]  deb_cnt_q, deb_cnt_d;
  logic [9:0]  key_q, key_d;
  logic [15:0] digits_q, digits_d;   // {min_tens, min_ones, sec_tens, sec_ones}
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic        key_valid_q, key_valid_d;
  logic        onehot;
  logic        accept;
  logic [3:0]  key_bcd;

  // Zero and multi-key samples both fail this test.
  assign onehot = (keyboard != '0) && ((keyboard & (keyboard - 10'd1)) == '0);

  always_comb begin
    key_bcd = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_q[i]) key_bcd = 4'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    key_d       = key_q;
    digits_d    = digits_q;
    digit_cnt_d = digit_cnt_q;
    key_valid_d = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (onehot) begin
          key_d     = keyboard;
          deb_cnt_d = 8'd1;
          state_d   = StDebounce;
        end
      end
      StDebounce: begin
        if (keyboard == key_q) begin
          if (deb_cnt_q + 8'd1 == DebMax) begin
            accept    = 1'b1;
            deb_cnt_d = 8'd0;
            state_d   = StWaitRel;
          end else begin
            deb_cnt_d = deb_cnt_q + 8'd1;
          end
        end else begin
          deb_cnt_d = 8'd0;
          state_d   = StIdle;
        end
      end
      StWaitRel: begin
        if (keyboard == '0) state_d = StIdle;
      end
      default: begin
        deb_cnt_d = 8'd0;
        state_d   = StIdle;
      end
    endcase

    // A full entry swallows the key but the FSM still waits for release.
    if (accept && (digit_cnt_q < 3'd4)) begin
      digits_d    = {digits_q[11:0], key_bcd};
      digit_cnt_d = digit_cnt_q + 3'd1;
      key_valid_d = 1'b1;
    end

    if (enablen) begin
      state_d     = StIdle;
      deb_cnt_d   = 8'd0;
      digits_d    = digits_q;
      digit_cnt_d = digit_cnt_q;
      key_valid_d = 1'b0;
    end

    // Going to WaitRel keeps a still-held key from being re-entered.
    if (clear) begin
      state_d     = StWaitRel;
      deb_cnt_d   = 8'd0;
      digits_d    = '0;
      digit_cnt_d = 3'd0;
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      deb_cnt_q   <= 8'd0;
      key_q       <= '0;
      digits_q    <= '0;
      digit_cnt_q <= 3'd0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      key_q       <= key_d;
      digits_q    <= digits_d;
      digit_cnt_q <= digit_cnt_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign sec_ones   = digits_q[3:0];
  assign sec_tens   = digits_q[7:4];
  assign min_ones   = digits_q[11:8];
  assign min_tens   = digits_q[15:12];
  assign digit_cnt  = digit_cnt_q;
  assign key_valid  = key_valid_q;
  assign entry_full = (digit_cnt_q == 3'd4);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl with DEB_CYCLES = 4.
module tb_keypad_entry_ctrl;

  logic       clk;
  logic       reset;
  logic [9:0] keyboard;
  logic       enablen;
  logic       clear;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [2:0] digit_cnt;
  logic       key_valid;
  logic       entry_full;

  int total = 0;
  int bad = 0;
  int kv_cnt = 0;
  int kv_base;

  keypad_entry_ctrl #(.DEB_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .keyboard   (keyboard),
    .enablen    (enablen),
    .clear      (clear),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .digit_cnt  (digit_cnt),
    .key_valid  (key_valid),
    .entry_full (entry_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count key_valid pulses away from the active edge.
  always @(negedge clk) if (key_valid) kv_cnt <= kv_cnt + 1;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    keyboard = '0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Hold digit d for 6 cycles, check the 4-sample latency, then release 3.
  task automatic press(input int d, input bit acc);
    keyboard = 10'(1 << d);
    step(3);
    check("kv_early", int'(key_valid), 0);
    step(1);
    check("kv_at_4", int'(key_valid), int'(acc));
    if (acc) check("new_digit", int'(sec_ones), d);
    step(2);
    keyboard = '0;
    step(3);
  endtask

  task automatic check_digits(input string tag, input int mt, input int mo,
                              input int st, input int so);
    check({tag, "_min_tens"}, int'(min_tens), mt);
    check({tag, "_min_ones"}, int'(min_ones), mo);
    check({tag, "_sec_tens"}, int'(sec_tens), st);
    check({tag, "_sec_ones"}, int'(sec_ones), so);
  endtask

  initial begin
    reset = 1'b1;
    keyboard = 10'h200;
    enablen = 1'b0;
    clear = 1'b0;

    // Reset with key 9 held
    step(2);
    check_digits("rst", 0, 0, 0, 0);
    check("rst_cnt", int'(digit_cnt), 0);
    check("rst_kv", int'(key_valid), 0);
    check("rst_full", int'(entry_full), 0);
    reset = 1'b0;
    step(3);
    check("rst_kv_hold", int'(key_valid), 0);
    step(1);
    check("rst_kv_after", int'(key_valid), 1);
    check("rst_digit9", int'(sec_ones), 9);

    // Entry 1, 2, 3
    do_reset();
    kv_base = kv_cnt;
    press(1, 1'b1);
    press(2, 1'b1);
    press(3, 1'b1);
    check_digits("entry", 0, 1, 2, 3);
    check("entry_cnt", int'(digit_cnt), 3);
    check("entry_pulses", kv_cnt - kv_base, 3);
    check("entry_full0", int'(entry_full), 0);

    // Bounce
    do_reset();
    kv_base = kv_cnt;
    for (int i = 0; i < 3; i++) begin
      keyboard = 10'h004;
      step(2);
      keyboard = '0;
      step(2);
    end
    keyboard = 10'h004;
    step(4);
    keyboard = '0;
    step(3);
    check("bounce_pulses", kv_cnt - kv_base, 1);
    check("bounce_digit", int'(sec_ones), 2);
    check("bounce_cnt", int'(digit_cnt), 1);

    // Overflow
    do_reset();
    kv_base = kv_cnt;
    press(5, 1'b1);
    press(9, 1'b1);
    press(0, 1'b1);
    press(0, 1'b1);
    check("ovf_full_before", int'(entry_full), 1);
    press(7, 1'b0);
    check_digits("ovf", 5, 9, 0, 0);
    check("ovf_cnt", int'(digit_cnt), 4);
    check("ovf_full", int'(entry_full), 1);
    check("ovf_pulses", kv_cnt - kv_base, 4);

    // Multi-key and gating
    do_reset();
    kv_base = kv_cnt;
    keyboard = 10'h003;
    step(10);
    keyboard = '0;
    step(2);
    check("multi_cnt", int'(digit_cnt), 0);
    check("multi_pulses", kv_cnt - kv_base, 0);
    enablen = 1'b1;
    keyboard = 10'h010;
    step(10);
    check("gate_cnt", int'(digit_cnt), 0);
    check("gate_pulses", kv_cnt - kv_base, 0);
    enablen = 1'b0;
    step(3);
    check("gate_kv_early", int'(key_valid), 0);
    step(1);
    check("gate_kv", int'(key_valid), 1);
    check("gate_digit", int'(sec_ones), 4);
    keyboard = '0;
    step(3);
    check("gate_pulses2", kv_cnt - kv_base, 1);

    // Clear while key 8 held, digits = 1,2
    do_reset();
    press(1, 1'b1);
    press(2, 1'b1);
    kv_base = kv_cnt;
    keyboard = 10'h100;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_digits("clr", 0, 0, 0, 0);
    check("clr_cnt", int'(digit_cnt), 0);
    step(8);
    check("clr_held_pulses", kv_cnt - kv_base, 0);
    check("clr_held_cnt", int'(digit_cnt), 0);
    keyboard = '0;
    step(2);
    press(8, 1'b1);
    check("clr_repress_cnt", int'(digit_cnt), 1);

    // Clear on the acceptance edge loses the key
    keyboard = 10'h100;
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_acc_kv", int'(key_valid), 0);
    check("clr_acc_cnt", int'(digit_cnt), 0);
    check("clr_acc_digit", int'(sec_ones), 0);
    keyboard = '0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
